alu_issue_stage: RTL

- ID/EX issue stage that feeds the ALU: the ALU-control encoder for the ALU's 4-bit operation code.
- Decodes a fetched RV32 instruction plus register-file read data into ALU operand A, operand B and the ALU control code.
- Registers the result behind a valid/ready handshake, backed by a 2-entry skid buffer.
- Sits between the register-file read and the ALU/EX stage.

---
 rtl/alu_issue_pkg.sv | 41 ++++
 rtl/alu_ctrl_decode.sv | 69 ++++++
 rtl/alu_issue_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU codes, opcodes, issue bundle type and decode helpers for alu_issue_stage
package alu_issue_pkg;
  localparam int DATA_W = 32;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CODE_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CODE_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CODE_W-1:0] ALU_MUL = 4'b0011;
  localparam logic [CODE_W-1:0] ALU_SLL = 4'b0100;
  localparam logic [CODE_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [CODE_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CODE_W-1:0] ALU_XOR = 4'b0111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;
  typedef struct packed {
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CODE_W-1:0] alu_ctrl;
    logic [4:0]        rd;
    logic              reg_write;
    logic              is_branch;
    logic              illegal;
  } bundle_t;
  localparam bundle_t BUNDLE_RST = '{alu_a: '0, alu_b: '0, alu_ctrl: ALU_ADD, rd: '0,
                                     reg_write: 1'b0, is_branch: 1'b0, illegal: 1'b0};
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
  // funct3 -> ALU code shared by register and immediate ALU ops; unlisted funct3 falls back to ADD
  function automatic logic [CODE_W-1:0] alu_code(input logic [2:0] f3);
    return f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR : f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b001 ? ALU_SLL : f3 == 3'b101 ? ALU_SRL : ALU_ADD;
  endfunction
  function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
    return {{(DATA_W-12){v[11]}}, v};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational RV32 instr + rs data -> ALU issue bundle (illegal flag under ILLEGAL_TRAP_EN)
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output bundle_t           bundle
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic ok, wr, br, shift;
  logic [CODE_W-1:0] ctrl;
  logic [DATA_W-1:0] b;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  // Classify the encoding, then squash anything unrecognised into a NOP bundle
  always_comb begin
    ok = 1'b0;
    wr = 1'b0;
    br = 1'b0;
    ctrl = ALU_ADD;
    b = '0;
    case (op)
      OP_R: begin
        b = rs2_data;
        wr = 1'b1;
        ok = (f7 == F7_BASE && f3 != 3'b010 && f3 != 3'b011) ||
             (f3 == 3'b000 && (f7 == F7_ALT || f7 == F7_MUL));
        ctrl = f7 == F7_ALT ? ALU_SUB : f7 == F7_MUL ? ALU_MUL : alu_code(f3);
      end
      OP_IMM: begin
        wr = 1'b1;
        ok = shift ? f7 == F7_BASE : f3 != 3'b010 && f3 != 3'b011;
        ctrl = alu_code(f3);
        b = shift ? {{(DATA_W-5){1'b0}}, instr[24:20]} : sext12(instr[31:20]);
      end
      OP_LOAD: begin
        ok = 1'b1;
        wr = 1'b1;
        b = sext12(instr[31:20]);
      end
      OP_STORE: begin
        ok = 1'b1;
        b = sext12({instr[31:25], instr[11:7]});
      end
      OP_BRANCH: begin
        ok = f3 == 3'b000 || f3 == 3'b001;
        br = 1'b1;
        ctrl = ALU_SUB;
        b = rs2_data;
      end
      default: ok = 1'b0;
    endcase
    bundle.alu_a = ok ? rs1_data : '0;
    bundle.alu_b = ok ? b : '0;
    bundle.alu_ctrl = ok ? ctrl : ALU_ADD;
    bundle.rd = ok ? instr[11:7] : 5'd0;
    bundle.reg_write = ok && wr && instr[11:7] != 5'd0;
    bundle.is_branch = ok && br;
`ifdef ILLEGAL_TRAP_EN
    bundle.illegal = !ok && !(op == OP_IMM && instr[31:7] == 25'd0);
`else
    bundle.illegal = 1'b0;
`endif
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register with 2-entry skid buffer; ILLEGAL_TRAP_EN adds illegal_instr output
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              is_branch
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              illegal_instr
`endif
);
  occ_t state_q, state_d;
  bundle_t main_q, main_d, skid_q, skid_d, dec;
  logic accept, drain;
  alu_ctrl_decode u_dec (
    .instr   (instr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .bundle  (dec)
  );
  assign in_ready = state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  // Occupancy next-state and entry movement; flush overrides any accept or drain
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: begin
        state_d = accept ? ONE : EMPTY;
        if (accept) main_d = dec;
      end
      ONE: begin
        state_d = accept && !drain ? TWO : !accept && drain ? EMPTY : ONE;
        if (accept && drain) main_d = dec;
        if (accept && !drain) skid_d = dec;
      end
      TWO: begin
        state_d = drain ? ONE : TWO;
        if (drain) main_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // State and entry registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q <= BUNDLE_RST;
      skid_q <= BUNDLE_RST;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign alu_a = main_q.alu_a;
  assign alu_b = main_q.alu_b;
  assign alu_ctrl = main_q.alu_ctrl;
  assign rd = main_q.rd;
  assign reg_write = main_q.reg_write;
  assign is_branch = main_q.is_branch;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = main_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = main_q.illegal;
`endif
endmodule
